// File: rtl/div_share_arbiter.sv
// Round-robin arbiter sharing one Divider among NREQ requesters.
// Optional DIV_DVZ_BYPASS_EN: zero divisors are answered directly without starting the Divider.
module div_share_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 10,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              sclr_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_in,
    input  logic [NREQ*W-1:0] b_in,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W-1:0]      rsp_q,
    output logic              rsp_dvz,
    output logic              rsp_ovf,
    output logic [IDW-1:0]    rsp_id,
    output logic              div_start,
    output logic [W-1:0]      div_a,
    output logic [W-1:0]      div_b,
    input  logic              div_busy,
    input  logic              div_valid,
    input  logic [W-1:0]      div_out,
    input  logic              div_dvz,
    input  logic              div_ovf
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  grant_id;
    logic            grant_found;
    logic            grant_ok;
    logic            grant_zero_b;
    logic [W-1:0]    a_sel;
    logic [W-1:0]    b_sel;
    logic [NREQ-1:0] ack_r;
    logic [NREQ-1:0] rsp_valid_r;
    int              idx;

    // First pending request at or above rr_ptr, wrapping past NREQ-1.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!grant_found && req[IDW'(idx)]) begin
                grant_found = 1'b1;
                grant_id    = IDW'(idx);
            end
        end
    end

    assign grant_ok = (state == IDLE) && grant_found && !div_busy;
    assign a_sel    = a_in[grant_id*W +: W];
    assign b_sel    = b_in[grant_id*W +: W];

`ifdef DIV_DVZ_BYPASS_EN
    assign grant_zero_b = (b_sel == '0);
`else
    assign grant_zero_b = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!sclr_n) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_ok) state_nxt = grant_zero_b ? RESP : ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (div_valid) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operands stay latched from one grant to the next so the Divider sees stable inputs.
    always_ff @(posedge clk) begin
        if (!sclr_n) begin
            rr_ptr      <= '0;
            ack_r       <= '0;
            rsp_valid_r <= '0;
            rsp_q       <= '0;
            rsp_dvz     <= 1'b0;
            rsp_ovf     <= 1'b0;
            rsp_id      <= '0;
            div_a       <= '0;
            div_b       <= '0;
        end else begin
            ack_r       <= '0;
            rsp_valid_r <= '0;
            case (state)
                IDLE: begin
                    if (grant_ok) begin
                        div_a  <= a_sel;
                        div_b  <= b_sel;
                        rsp_id <= grant_id;
                        ack_r  <= NREQ'(1) << grant_id;
                        if (grant_zero_b) begin
                            rsp_q   <= '1;
                            rsp_dvz <= 1'b1;
                            rsp_ovf <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (div_valid) begin
                        rsp_q   <= div_out;
                        rsp_dvz <= div_dvz;
                        rsp_ovf <= div_ovf;
                    end
                end
                RESP: begin
                    rsp_valid_r <= NREQ'(1) << rsp_id;
                    rr_ptr      <= (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        div_start = (state == ISSUE);
        ack       = ack_r;
        rsp_valid = rsp_valid_r;
    end

endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed bench for div_share_arbiter with a fixed-latency behavioural Divider.
// Expectations follow DIV_DVZ_BYPASS_EN when it is defined for the build.
module tb_div_share_arbiter;

    localparam int NREQ    = 4;
    localparam int W       = 10;
    localparam int IDW     = 2;
    localparam int DIV_LAT = 3;

    logic              clk = 1'b0;
    logic              sclr_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] a_in;
    logic [NREQ*W-1:0] b_in;
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_q;
    logic              rsp_dvz;
    logic              rsp_ovf;
    logic [IDW-1:0]    rsp_id;
    logic              div_start;
    logic [W-1:0]      div_a;
    logic [W-1:0]      div_b;
    logic              div_busy;
    logic              div_valid;
    logic [W-1:0]      div_out;
    logic              div_dvz;
    logic              div_ovf;

    logic              ext_busy = 1'b0;
    logic [NREQ-1:0]   hold_mask = '0;

    logic              m_busy  = 1'b0;
    logic              m_valid = 1'b0;
    logic              m_dvz   = 1'b0;
    logic [W-1:0]      m_out   = '0;
    logic [W-1:0]      m_a     = '0;
    logic [W-1:0]      m_b     = '0;
    int                m_cnt   = 0;

    int test_cnt  = 0;
    int fail_cnt  = 0;
    int cyc       = 0;
    int start_cnt = 0;
    int ack_ids[$];
    int ack_cyc[$];
    int rsp_ids[$];
    int rsp_qs[$];
    int rsp_dvzs[$];
    int rsp_ovfs[$];
    int rsp_cyc[$];

    div_share_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk       (clk),
        .sclr_n    (sclr_n),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .ack       (ack),
        .rsp_valid (rsp_valid),
        .rsp_q     (rsp_q),
        .rsp_dvz   (rsp_dvz),
        .rsp_ovf   (rsp_ovf),
        .rsp_id    (rsp_id),
        .div_start (div_start),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_busy  (div_busy),
        .div_valid (div_valid),
        .div_out   (div_out),
        .div_dvz   (div_dvz),
        .div_ovf   (div_ovf)
    );

    always #5 clk = ~clk;

    assign div_busy  = m_busy | ext_busy;
    assign div_valid = m_valid;
    assign div_out   = m_out;
    assign div_dvz   = m_dvz;
    assign div_ovf   = 1'b0;

    // Divider stand-in: valid arrives DIV_LAT edges after start is captured; zero divisor gives 0x155 with dvz.
    always @(posedge clk) begin
        m_valid <= 1'b0;
        if (m_busy) begin
            if (m_cnt == 1) begin
                m_busy  <= 1'b0;
                m_valid <= 1'b1;
                if (m_b == '0) begin
                    m_out <= W'(10'h155);
                    m_dvz <= 1'b1;
                end else begin
                    m_out <= m_a / m_b;
                    m_dvz <= 1'b0;
                end
            end
            m_cnt <= m_cnt - 1;
        end else if (div_start) begin
            m_busy <= 1'b1;
            m_cnt  <= DIV_LAT;
            m_a    <= div_a;
            m_b    <= div_b;
        end
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        test_cnt++;
        if (actual !== expected) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int i, input int a, input int b);
        a_in[i*W +: W] = W'(a);
        b_in[i*W +: W] = W'(b);
    endtask

    task automatic clearLogs();
        start_cnt = 0;
        ack_ids.delete();
        ack_cyc.delete();
        rsp_ids.delete();
        rsp_qs.delete();
        rsp_dvzs.delete();
        rsp_ovfs.delete();
        rsp_cyc.delete();
    endtask

    // One clock: sample just after the edge, log pulses, and let requesters drop req on ack.
    task automatic stepCycle();
        @(posedge clk);
        #1;
        cyc++;
        if (div_start) start_cnt++;
        for (int i = 0; i < NREQ; i++) begin
            if (ack[i]) begin
                ack_ids.push_back(i);
                ack_cyc.push_back(cyc);
                if (!hold_mask[i]) req[i] = 1'b0;
            end
            if (rsp_valid[i]) begin
                rsp_ids.push_back(i);
                rsp_qs.push_back(int'(rsp_q));
                rsp_dvzs.push_back(int'(rsp_dvz));
                rsp_ovfs.push_back(int'(rsp_ovf));
                rsp_cyc.push_back(cyc);
            end
        end
    endtask

    task automatic runCycles(input int n);
        for (int k = 0; k < n; k++) stepCycle();
    endtask

    task automatic waitRsp(input int n, input int budget);
        int k;
        k = 0;
        while (rsp_ids.size() < n && k < budget) begin
            stepCycle();
            k++;
        end
        checkOutput("rsp_count", rsp_ids.size(), n);
    endtask

    task automatic doReset(input logic [NREQ-1:0] r);
        req    = r;
        sclr_n = 1'b0;
        runCycles(2);
        sclr_n = 1'b1;
        clearLogs();
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_ack"}, int'(ack), 0);
        checkOutput({tag, "_rsp_valid"}, int'(rsp_valid), 0);
        checkOutput({tag, "_div_start"}, int'(div_start), 0);
        checkOutput({tag, "_rsp_q"}, int'(rsp_q), 0);
        checkOutput({tag, "_rsp_dvz"}, int'(rsp_dvz), 0);
        checkOutput({tag, "_rsp_ovf"}, int'(rsp_ovf), 0);
        checkOutput({tag, "_rsp_id"}, int'(rsp_id), 0);
        checkOutput({tag, "_div_a"}, int'(div_a), 0);
        checkOutput({tag, "_div_b"}, int'(div_b), 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        sclr_n = 1'b0;
        req    = '0;
        a_in   = '0;
        b_in   = '0;

        doReset('0);
        checkIdleOutputs("reset");

        // Single operation: 179 / 9
        applyStimulus(0, 179, 9);
        req = 4'b0001;
        waitRsp(1, 50);
        checkOutput("single_ack_count", ack_ids.size(), 1);
        if (ack_ids.size() > 0) checkOutput("single_ack_id", ack_ids[0], 0);
        checkOutput("single_starts", start_cnt, 1);
        if (rsp_ids.size() > 0) begin
            checkOutput("single_rsp_id", rsp_ids[0], 0);
            checkOutput("single_q", rsp_qs[0], 19);
            checkOutput("single_dvz", rsp_dvzs[0], 0);
            checkOutput("single_ovf", rsp_ovfs[0], 0);
            if (ack_cyc.size() > 0) checkOutput("single_latency", rsp_cyc[0] - ack_cyc[0], 3 + DIV_LAT);
        end
        checkOutput("single_rsp_id_port", int'(rsp_id), 0);

        // All four requesters pending out of reset
        for (int i = 0; i < NREQ; i++) applyStimulus(i, 100 * (i + 1), 10);
        doReset(4'b1111);
        waitRsp(4, 100);
        for (int i = 0; i < NREQ; i++) begin
            if (rsp_ids.size() > i) begin
                checkOutput($sformatf("all_order_%0d", i), rsp_ids[i], i);
                checkOutput($sformatf("all_q_%0d", i), rsp_qs[i], 10 * (i + 1));
            end
        end
        checkOutput("all_starts", start_cnt, 4);

        // Fairness: requester 2 holds req while 0 and 1 pulse; pointer wraps 3 -> 0
        clearLogs();
        hold_mask = 4'b0100;
        req = 4'b0111;
        waitRsp(3, 100);
        if (rsp_ids.size() >= 3) checkOutput("fair_third_is_2", rsp_ids[2], 2);
        req[0] = 1'b1;
        waitRsp(5, 100);
        if (rsp_ids.size() >= 5) begin
            checkOutput("fair_wrap_to_0", rsp_ids[3], 0);
            checkOutput("fair_2_again", rsp_ids[4], 2);
            checkOutput("fair_2_q", rsp_qs[4], 30);
        end
        hold_mask = '0;
        req = '0;
        runCycles(3);

        // Divide by zero on requester 1
        clearLogs();
        applyStimulus(1, 55, 0);
        req = 4'b0010;
        waitRsp(1, 50);
        if (rsp_ids.size() > 0) begin
            checkOutput("dvz_rsp_id", rsp_ids[0], 1);
            checkOutput("dvz_flag", rsp_dvzs[0], 1);
            checkOutput("dvz_ovf", rsp_ovfs[0], 0);
`ifdef DIV_DVZ_BYPASS_EN
            checkOutput("dvz_q", rsp_qs[0], 1023);
            if (ack_cyc.size() > 0) checkOutput("dvz_latency", rsp_cyc[0] - ack_cyc[0], 1);
`else
            checkOutput("dvz_q", rsp_qs[0], 341);
            if (ack_cyc.size() > 0) checkOutput("dvz_latency", rsp_cyc[0] - ack_cyc[0], 3 + DIV_LAT);
`endif
        end
`ifdef DIV_DVZ_BYPASS_EN
        checkOutput("dvz_starts", start_cnt, 0);
`else
        checkOutput("dvz_starts", start_cnt, 1);
`endif
        runCycles(3);

        // External agent holds div_busy for 20 cycles
        clearLogs();
        applyStimulus(0, 100, 10);
        ext_busy = 1'b1;
        req = 4'b0001;
        runCycles(20);
        checkOutput("busy_no_ack", ack_ids.size(), 0);
        checkOutput("busy_no_start", start_cnt, 0);
        ext_busy = 1'b0;
        stepCycle();
        checkOutput("busy_release_ack", ack_ids.size(), 1);
        waitRsp(1, 50);
        if (rsp_ids.size() > 0) checkOutput("busy_q", rsp_qs[0], 10);
        runCycles(3);

        // Reset while waiting on the Divider
        clearLogs();
        applyStimulus(1, 50, 5);
        req = 4'b0010;
        n = 0;
        while (ack_ids.size() == 0 && n < 20) begin
            stepCycle();
            n++;
        end
        checkOutput("wait_ack_seen", ack_ids.size(), 1);
        stepCycle();
        sclr_n = 1'b0;
        stepCycle();
        sclr_n = 1'b1;
        checkIdleOutputs("midreset");
        clearLogs();
        runCycles(10);
        checkOutput("midreset_no_rsp", rsp_ids.size(), 0);
        checkOutput("midreset_no_start", start_cnt, 0);
        applyStimulus(3, 81, 9);
        req = 4'b1000;
        waitRsp(1, 50);
        if (rsp_ids.size() > 0) begin
            checkOutput("after_reset_id", rsp_ids[0], 3);
            checkOutput("after_reset_q", rsp_qs[0], 9);
        end
        checkOutput("after_reset_rsp_id_port", int'(rsp_id), 3);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
